// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles every non-clock/reset signal of the instruction-fetch stage.
//   master : the fetch unit (drives requests and the IF/ID head)
//   slave  : the environment (instruction memory, ID/EX redirect, IF/ID)
// Signal groups:
//   req_*      fetch request to instruction memory (valid/ready)
//   resp_*     in-order memory response, no backpressure
//   redirect_* taken branch/jump target from ID/EX
//   inst_*     prefetch FIFO head presented to IF/ID (valid/ready)
//   fifo_count current prefetch FIFO occupancy
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [CW-1:0]   fifo_count;

  modport master (
    output req_valid, req_addr,
    input  req_ready,
    input  resp_valid, resp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc, fifo_count,
    input  inst_ready
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready,
    output resp_valid, resp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc, fifo_count,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Owns the PC, issues fetch requests over a
// latency-tolerant valid/ready handshake, buffers in-order responses in a
// DEPTH-entry prefetch FIFO and presents {inst, inst_pc} to IF/ID. A redirect
// flushes the FIFO and marks every in-flight response for discard.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      fetch_unit_if.master (request, response, redirect, IF/ID head,
//            fifo_count)
// Parameters:
//   XLEN          address / instruction width
//   DEPTH         FIFO entries (power of two, >=2); also caps requests in flight
//   RESET_VECTOR  first fetch address after reset (4-byte aligned)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fetch_unit_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          r_fifo [DEPTH];
  logic [XLEN-1:0] r_pc;      // next request address
  logic [XLEN-1:0] r_rpc;     // PC tag for the next kept response
  logic [CW-1:0]   r_outst;   // requests issued, not yet answered
  logic [CW-1:0]   r_drop;    // in-flight responses still to discard
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_credit;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_resp_ok;
  logic            w_push;
  logic            w_pop;

  assign w_redirect = bus.redirect_valid;
  assign w_target   = bus.redirect_pc & ~XLEN'(3);

  // Requests in flight reserve a FIFO slot, so a response can never find the
  // FIFO full. Dropped-pending requests still hold their credit until they
  // come back. One extra bit keeps the sum from overflowing.
  assign w_credit    = ({1'b0, r_count} + {1'b0, r_outst}) < (CW+1)'(DEPTH);
  assign w_req_valid = i_rst_n & ~w_redirect & w_credit;
  assign w_req_fire  = w_req_valid & bus.req_ready;

  // A response with nothing outstanding is a memory protocol error; ignore it.
  assign w_resp_ok = bus.resp_valid & (r_outst != '0);
  assign w_push    = w_resp_ok & (r_drop == '0) & ~w_redirect;
  assign w_pop     = (r_count != '0) & bus.inst_ready & ~w_redirect;

  assign bus.req_valid  = w_req_valid;
  assign bus.req_addr   = r_pc;
  assign bus.inst_valid = (r_count != '0);
  assign bus.inst       = r_fifo[r_rd].inst;
  assign bus.inst_pc    = r_fifo[r_rd].pc;
  assign bus.fifo_count = r_count;

  // Control state: PC, response tag, credits, discard counter, occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_rpc   <= RESET_VECTOR;
      r_outst <= '0;
      r_drop  <= '0;
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      // w_req_fire is already 0 during a redirect, so outst is exact either way.
      r_outst <= r_outst + CW'(w_req_fire) - CW'(w_resp_ok);
      if (w_redirect) begin
        r_pc    <= w_target;
        r_rpc   <= w_target;
        // Everything still in flight after this cycle belongs to the old path.
        r_drop  <= r_outst - CW'(w_resp_ok);
        r_count <= '0;
        r_wr    <= '0;
        r_rd    <= '0;
      end else begin
        if (w_req_fire)
          r_pc <= r_pc + XLEN'(4);
        if (w_resp_ok && r_drop != '0)
          r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_rpc <= r_rpc + XLEN'(4);
          r_wr  <= r_wr + PW'(1);
        end
        if (w_pop)
          r_rd <= r_rd + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_fifo[i] <= '0;
    end else if (w_push) begin
      r_fifo[r_wr] <= '{inst: bus.resp_data, pc: r_rpc};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(32'h0)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Reference model: memory requests in flight tagged with the fetch "epoch"
  // (bumped on every redirect), and the FIFO as a queue of expected PCs.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] fq[$];
  logic [31:0] exp_req;
  logic [31:0] last_pop_pc;
  int cyc = 0, epoch = 0, lat = 1, n_pop = 0;
  int n_chk = 0, n_err = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_idle();
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_data      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    drive_idle();
    mq.delete();
    fq.delete();
    exp_req = 32'h0;
    epoch++;
    lat = l;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs against
  // the model, then advance the model to what the next rising edge does.
  task automatic step(input bit rr, input bit ir, input bit rd, input logic [31:0] tgt);
    bit    resp, exp_rv, pop;
    mreq_t m;
    resp = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.req_ready      = rr;
    bus.inst_ready     = ir;
    bus.redirect_valid = rd;
    bus.redirect_pc    = tgt;
    bus.resp_valid     = resp;
    if (resp) bus.resp_data = memf(mq[0].addr);
    else      bus.resp_data = $urandom;
    #1;
    exp_rv = !rd && ((fq.size() + mq.size()) < DEPTH);
    n_chk++;
    if (bus.req_valid !== exp_rv) begin
      n_err++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.req_valid, exp_rv);
    end
    if (exp_rv) begin
      n_chk++;
      if (bus.req_addr !== exp_req) begin
        n_err++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.req_addr, exp_req);
      end
    end
    n_chk++;
    if (bus.fifo_count !== fq.size()) begin
      n_err++;
      $display("FAIL fifo_count cyc=%0d got=%0d exp=%0d", cyc, bus.fifo_count, fq.size());
    end
    n_chk++;
    if (bus.inst_valid !== (fq.size() != 0)) begin
      n_err++;
      $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, bus.inst_valid, fq.size() != 0);
    end
    if (fq.size() != 0) begin
      n_chk++;
      if (bus.inst_pc !== fq[0] || bus.inst !== memf(fq[0])) begin
        n_err++;
        $display("FAIL head cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                 cyc, bus.inst_pc, bus.inst, fq[0], memf(fq[0]));
      end
    end
    pop = ir && (fq.size() != 0);
    if (rd) begin
      fq.delete();
      if (resp) m = mq.pop_front();   // answered in the redirect cycle: discarded
      epoch++;
      exp_req = tgt & ~32'h3;
    end else begin
      if (pop) begin
        last_pop_pc = bus.inst_pc;
        void'(fq.pop_front());
        n_pop++;
      end
      if (resp) begin
        m = mq.pop_front();
        if (m.ep == epoch) fq.push_back(m.addr);
      end
      if (exp_rv && rr) begin
        mq.push_back('{addr: exp_req, due: cyc + lat, ep: epoch});
        exp_req = exp_req + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    n_chk++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got=%b exp=0", bus.req_valid); end
    n_chk++; if (bus.req_addr !== 32'h0) begin n_err++; $display("FAIL rst_req_addr got=%h exp=0", bus.req_addr); end
    n_chk++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid got=%b exp=0", bus.inst_valid); end
    n_chk++; if (bus.inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got=%h exp=0", bus.inst); end
    n_chk++; if (bus.inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc got=%h exp=0", bus.inst_pc); end
    n_chk++; if (bus.fifo_count !== 0) begin n_err++; $display("FAIL rst_fifo_count got=%0d exp=0", bus.fifo_count); end
  endtask

  // 1-cycle memory, always ready: first instruction two cycles after the
  // first request, then one per cycle with no gaps.
  task automatic test_stream();
    int n0;
    do_reset(1);
    n0 = n_pop;
    repeat (20) step(1, 1, 0, 0);
    n_chk++;
    if (n_pop - n0 != 18) begin
      n_err++;
      $display("FAIL stream_throughput got=%0d exp=18", n_pop - n0);
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    repeat (5) step(1, 1, 0, 0);
    repeat (10) step(1, 0, 0, 0);
    n_chk++; if (bus.fifo_count !== DEPTH) begin n_err++; $display("FAIL stall_full got=%0d exp=%0d", bus.fifo_count, DEPTH); end
    n_chk++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_req got=%b exp=0", bus.req_valid); end
    repeat (15) step(1, 1, 0, 0);
  endtask

  task automatic test_redirect_latency();
    bit seen;
    do_reset(3);
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h100);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1, 0, 0, 0);
      if (bus.inst_valid === 1'b1) seen = 1;
    end
    n_chk++;
    if (!seen) begin
      n_err++;
      $display("FAIL redir_lat_timeout got=no inst_valid exp=inst_valid within 20 cycles");
    end else if (bus.inst_pc !== 32'h100 || bus.inst !== memf(32'h100)) begin
      n_err++;
      $display("FAIL redir_lat_first got pc=%h inst=%h exp pc=00000100 inst=%h",
               bus.inst_pc, bus.inst, memf(32'h100));
    end
    repeat (10) step(1, 1, 0, 0);
  endtask

  // Redirect coinciding with a response and a pop; target low bits ignored.
  task automatic test_redirect_collide();
    do_reset(1);
    repeat (6) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h103);
    n_chk++; if (bus.fifo_count !== 0) begin n_err++; $display("FAIL collide_flush got=%0d exp=0", bus.fifo_count); end
    n_chk++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL collide_inst_valid got=%b exp=0", bus.inst_valid); end
    repeat (2) step(1, 1, 0, 0);
    n_chk++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst !== memf(32'h100)) begin
      n_err++;
      $display("FAIL collide_n3 got v=%b pc=%h inst=%h exp v=1 pc=00000100 inst=%h",
               bus.inst_valid, bus.inst_pc, bus.inst, memf(32'h100));
    end
    repeat (5) step(1, 1, 0, 0);
  endtask

  task automatic test_wrap();
    do_reset(1);
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 1, 32'hFFFF_FFF8);
    repeat (5) step(1, 1, 0, 0);
    n_chk++;
    if (last_pop_pc !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_pc got=%h exp=00000000", last_pop_pc);
    end
    repeat (5) step(1, 1, 0, 0);
  endtask

  task automatic test_reset_midstream();
    int k;
    do_reset(1);
    repeat (6) step(1, 1, 0, 0);
    k = 0;
    while (fq.size() < 3 && k < 10) begin
      step(1, 0, 0, 0);
      k++;
    end
    n_chk++;
    if (bus.fifo_count !== 3) begin
      n_err++;
      $display("FAIL mid_prefill got=%0d exp=3", bus.fifo_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.req_valid !== 1'b0 || bus.req_addr !== 32'h0 || bus.inst_valid !== 1'b0 ||
        bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || bus.fifo_count !== 0) begin
      n_err++;
      $display("FAIL mid_async_reset got rv=%b ra=%h iv=%b i=%h ip=%h cnt=%0d exp all zero",
               bus.req_valid, bus.req_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.fifo_count);
    end
    do_reset(1);
    repeat (10) step(1, 1, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    bit rr, ir, rd;
    for (int seg = 0; seg < 15; seg++) begin
      do_reset($urandom_range(5, 1));
      for (int c = 0; c < 200; c++) begin
        rr = ($urandom % 4) != 0;
        ir = ($urandom % 3) != 0;
        rd = ($urandom % 20) == 0;
        if ($urandom % 8 == 0) tgt = 32'hFFFF_FFF0 | ($urandom % 16);
        else                   tgt = $urandom;
        step(rr, ir, rd, tgt);
      end
    end
  endtask

  initial begin
    drive_idle();
    exp_req = 32'h0;
    last_pop_pc = 32'hDEAD_BEEF;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_redirect_collide();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
